// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding-mode and exception-flag types for the FPU datapath
package fpu_pkg;
  typedef enum logic [1:0] {RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11} round_mode_t;
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;
endpackage

// File: rtl/rounding_normalizer_pipe_if.sv
// rounding_normalizer_pipe_if: operand-in and packed-result handshake bundle
interface rounding_normalizer_pipe_if import fpu_pkg::*; #(
  parameter int EXP_WIDTH  = 10,
  parameter int EXP_FIELD  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int TAG_WIDTH  = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_sign;
  logic signed [EXP_WIDTH-1:0] in_exponent;
  logic [FRAC_WIDTH:0]         in_significand;
  logic                        in_guard;
  logic                        in_sticky;
  logic                        in_zero;
  round_mode_t                 in_mode;
  logic [TAG_WIDTH-1:0]        in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sign;
  logic [EXP_FIELD-1:0]        out_exponent;
  logic [FRAC_WIDTH-1:0]       out_fraction;
  logic [TAG_WIDTH-1:0]        out_tag;
  logic                        out_overflow;
  logic                        out_underflow;
  logic                        out_inexact;
  modport slave (
    input  in_valid, in_sign, in_exponent, in_significand, in_guard, in_sticky, in_zero, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_fraction, out_tag, out_overflow, out_underflow, out_inexact
  );
  modport master (
    output in_valid, in_sign, in_exponent, in_significand, in_guard, in_sticky, in_zero, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_fraction, out_tag, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/rounding_normalizer_pack.sv
// rounding_normalizer_pack: renormalise on carry-out, re-bias, saturate/flush and pack
module rounding_normalizer_pack import fpu_pkg::*; #(
  parameter int EXP_WIDTH  = 10,
  parameter int EXP_FIELD  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int BIAS       = 127
) (
  input  logic [FRAC_WIDTH+1:0]       rounded,
  input  logic signed [EXP_WIDTH-1:0] exponent,
  input  logic                        sign,
  input  logic                        zero,
  input  logic                        inexact,
  input  round_mode_t                 mode,
  output logic [EXP_FIELD-1:0]        exp_field,
  output logic [FRAC_WIDTH-1:0]       fraction,
  output fp_flags_t                   flags
);
  localparam logic signed [EXP_WIDTH:0] EMAX = (EXP_WIDTH+1)'((1 << EXP_FIELD) - 1);
  logic                      carry, ovf, unf, to_inf;
  logic signed [EXP_WIDTH:0] biased;
  logic [FRAC_WIDTH-1:0]     frac_n;
  always_comb begin
    carry     = rounded[FRAC_WIDTH+1];
    biased    = $signed({exponent[EXP_WIDTH-1], exponent}) + (EXP_WIDTH+1)'(BIAS) + $signed({{EXP_WIDTH{1'b0}}, carry});
    frac_n    = carry ? rounded[FRAC_WIDTH:1] : rounded[FRAC_WIDTH-1:0];
    ovf       = ~zero & (biased >= EMAX);
    unf       = ~zero & (biased[EXP_WIDTH] | (biased == '0));
    // directed modes only round to infinity when rounding away from zero
    to_inf    = (mode == RNE) | ((mode == RUP) & ~sign) | ((mode == RDN) & sign);
    exp_field = (zero | unf) ? '0 : ovf ? (to_inf ? '1 : {{(EXP_FIELD-1){1'b1}}, 1'b0}) : biased[EXP_FIELD-1:0];
    fraction  = (zero | unf | (ovf & to_inf)) ? '0 : ovf ? '1 : frac_n;
    flags     = '{overflow: ovf, underflow: unf, inexact: ~zero & (ovf | unf | inexact)};
  end
endmodule

// File: rtl/rounding_normalizer_pipe.sv
// rounding_normalizer_pipe: two-stage IEEE rounding and normalisation with valid/ready flow control
module rounding_normalizer_pipe import fpu_pkg::*; #(
  parameter int EXP_WIDTH  = 10,
  parameter int EXP_FIELD  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int BIAS       = 127,
  parameter int TAG_WIDTH  = 4
) (
  input logic clk,
  input logic reset,
  rounding_normalizer_pipe_if.slave bus
);
  logic                        inc, s2_take, in_rdy;
  logic                        s1_valid, s1_sign, s1_zero, s1_inexact;
  logic [FRAC_WIDTH+1:0]       s1_rounded;
  logic signed [EXP_WIDTH-1:0] s1_exp;
  round_mode_t                 s1_mode;
  logic [TAG_WIDTH-1:0]        s1_tag;
  logic [EXP_FIELD-1:0]        pk_exp;
  logic [FRAC_WIDTH-1:0]       pk_frac;
  fp_flags_t                   pk_flags;
  always_comb begin
    inc = (bus.in_mode == RNE) ? bus.in_guard & (bus.in_sticky | bus.in_significand[0]) :
          (bus.in_mode == RUP) ? ~bus.in_sign & (bus.in_guard | bus.in_sticky) :
          (bus.in_mode == RDN) ? bus.in_sign & (bus.in_guard | bus.in_sticky) : 1'b0;
    s2_take = ~bus.out_valid | bus.out_ready;
    in_rdy  = ~s1_valid | s2_take;
  end
  assign bus.in_ready = in_rdy;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_inexact <= 1'b0;
      s1_rounded <= '0;
      s1_exp     <= '0;
      s1_mode    <= RNE;
      s1_tag     <= '0;
    end else if (in_rdy) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign    <= bus.in_sign;
        s1_zero    <= bus.in_zero;
        s1_inexact <= bus.in_guard | bus.in_sticky;
        s1_rounded <= (FRAC_WIDTH+2)'(bus.in_significand) + (FRAC_WIDTH+2)'(inc);
        s1_exp     <= bus.in_exponent;
        s1_mode    <= bus.in_mode;
        s1_tag     <= bus.in_tag;
      end
    end
  end
  rounding_normalizer_pack #(
    .EXP_WIDTH(EXP_WIDTH), .EXP_FIELD(EXP_FIELD), .FRAC_WIDTH(FRAC_WIDTH), .BIAS(BIAS)
  ) u_pack (
    .rounded(s1_rounded), .exponent(s1_exp), .sign(s1_sign), .zero(s1_zero), .inexact(s1_inexact),
    .mode(s1_mode), .exp_field(pk_exp), .fraction(pk_frac), .flags(pk_flags)
  );
  // output registers only change when the downstream side is not stalling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.out_sign      <= 1'b0;
      bus.out_exponent  <= '0;
      bus.out_fraction  <= '0;
      bus.out_tag       <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
      bus.out_inexact   <= 1'b0;
    end else if (s2_take) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sign      <= s1_sign;
        bus.out_exponent  <= pk_exp;
        bus.out_fraction  <= pk_frac;
        bus.out_tag       <= s1_tag;
        bus.out_overflow  <= pk_flags.overflow;
        bus.out_underflow <= pk_flags.underflow;
        bus.out_inexact   <= pk_flags.inexact;
      end
    end
  end
endmodule

// File: tb/tb_rounding_normalizer_pipe.sv
// tb_rounding_normalizer_pipe: directed vectors with a queue scoreboard and decoupled output monitor
module tb_rounding_normalizer_pipe import fpu_pkg::*;;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [3:0]  tag;
    logic        ov;
    logic        un;
    logic        ix;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    tests = 0;
  int    fails = 0;
  beat_t sb[$];
  beat_t cur, snap;
  logic  stalled = 1'b0;

  rounding_normalizer_pipe_if bus();
  rounding_normalizer_pipe dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  assign cur = {bus.out_sign, bus.out_exponent, bus.out_fraction, bus.out_tag,
                bus.out_overflow, bus.out_underflow, bus.out_inexact};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // drives one beat, holds it until accepted; called and returns at a negedge
  task automatic send(input logic sg, input int e, input logic [23:0] sig, input logic g, input logic s,
                      input logic z, input round_mode_t m, input logic [3:0] t,
                      input logic [7:0] xe, input logic [22:0] xf, input logic [2:0] xfl);
    int n;
    bus.in_sign = sg; bus.in_exponent = 10'(e); bus.in_significand = sig;
    bus.in_guard = g; bus.in_sticky = s; bus.in_zero = z; bus.in_mode = m; bus.in_tag = t;
    bus.in_valid = 1'b1;
    sb.push_back({sg, xe, xf, t, xfl});
    n = 0;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout tag=%0h got=in_ready_low expected=accept", t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  always begin
    @(negedge clk); #1;
    if (reset) stalled = 1'b0;
    else begin
      if (stalled) begin
        tests++;
        if (!(bus.out_valid && cur === snap)) begin
          fails++;
          $display("FAIL hold_stable got=%0b/%0h expected=1/%0h", bus.out_valid, cur, snap);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat got=%0h expected=none", cur);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL result_tag%0h got=%0h expected=%0h", e.tag, cur, e);
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap = cur;
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exponent = '0; bus.in_significand = '0;
    bus.in_guard = 1'b0; bus.in_sticky = 1'b0; bus.in_zero = 1'b0; bus.in_mode = RNE; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_data", 64'(cur), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    send(0, 0, 24'h800000, 0, 0, 0, RNE, 4'h1, 8'h7F, 23'h0, 3'b000);
    #1 check("latency_not_yet", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1 check("latency_two", 64'({bus.out_valid, bus.out_tag}), 64'h11);

    send(0, 0,    24'hFFFFFF, 1, 0, 0, RNE, 4'h2, 8'h80, 23'h0,      3'b001);
    send(0, 0,    24'h800000, 1, 0, 0, RNE, 4'h3, 8'h7F, 23'h0,      3'b001);
    send(0, 0,    24'h800001, 1, 0, 0, RNE, 4'h4, 8'h7F, 23'h000002, 3'b001);
    send(0, 127,  24'hFFFFFF, 1, 0, 0, RNE, 4'h5, 8'hFF, 23'h0,      3'b101);
    send(0, 127,  24'hFFFFFF, 1, 0, 0, RTZ, 4'h6, 8'hFE, 23'h7FFFFF, 3'b001);
    send(1, 127,  24'hFFFFFF, 1, 0, 0, RDN, 4'h7, 8'hFF, 23'h0,      3'b101);
    send(1, -127, 24'h800000, 0, 0, 0, RNE, 4'h8, 8'h00, 23'h0,      3'b011);
    send(1, 0,    24'h000000, 0, 0, 1, RNE, 4'h9, 8'h00, 23'h0,      3'b000);
    send(0, 0,    24'h800000, 0, 1, 0, RUP, 4'hA, 8'h7F, 23'h000001, 3'b001);
    send(0, 128,  24'h800000, 0, 0, 0, RTZ, 4'hB, 8'hFE, 23'h7FFFFF, 3'b101);
    send(1, 0,    24'h800000, 1, 1, 0, RUP, 4'hC, 8'h7F, 23'h0,      3'b001);
    send(1, -126, 24'h800000, 0, 0, 0, RNE, 4'hD, 8'h01, 23'h0,      3'b000);
    send(0, 200,  24'h800000, 0, 0, 0, RDN, 4'hE, 8'hFE, 23'h7FFFFF, 3'b101);

    // six tagged beats with a 4-cycle downstream stall starting after the second accept
    fork
      for (int t = 0; t < 6; t++)
        send(0, t, 24'h800000 | 24'(t), 0, 0, 0, RNE, 4'(t), 8'(127 + t), 23'(t), 3'b000);
      begin
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1 check("bp_in_ready_low", 64'({bus.in_ready, bus.out_valid}), 64'b01);
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain_bp", 64'(sb.size()), 64'd0);

    // reset with two beats held inside the pipe
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(0, 1, 24'h800000, 0, 0, 0, RNE, 4'h6, 8'h80, 23'h0, 3'b000);
    send(0, 2, 24'h800000, 0, 0, 0, RNE, 4'h7, 8'h81, 23'h0, 3'b000);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_data", 64'(cur), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1 check("no_stale_beat", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
